// File: rtl/width_packer.sv
// Packs LANES consecutive IN_W-bit beats into one OUT_W-bit word, with abort on a valid gap.
// Optional macro WIDTH_PACKER_PARTIAL_FLUSH_EN: emit a zero-padded partial word on abort instead of pulsing err_drop.
module width_packer #(
  parameter int IN_W      = 8,
  parameter int LANES     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [IN_W-1:0]              data_in,
  input  logic                         valid_in,
  output logic [IN_W*LANES-1:0]        data_out,
  output logic                         valid_out,
  output logic [$clog2(LANES+1)-1:0]   lanes_out,
  output logic                         partial_out,
  output logic                         err_drop
);

  localparam int OUT_W = IN_W * LANES;
  localparam int CW    = $clog2(LANES);
  localparam int LW    = $clog2(LANES + 1);
  localparam logic [CW-1:0] LAST = CW'(LANES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     count_q;
  logic [OUT_W-1:0]  acc_q;
  logic [OUT_W-1:0]  acc_d;
  logic [OUT_W-1:0]  data_q;
  logic [LW-1:0]     lanes_q;
  logic              valid_q;
  logic              err_q;
  int                lane;

  // Accumulator with the incoming beat dropped into the lane selected by the counter.
  always_comb begin
    acc_d = acc_q;
    lane  = (MSB_FIRST != 0) ? (LANES - 1 - int'(count_q)) : int'(count_q);
    for (int l = 0; l < LANES; l++) begin
      if (l == lane) begin
        acc_d[l*IN_W +: IN_W] = data_in;
      end
    end
  end

`ifdef WIDTH_PACKER_PARTIAL_FLUSH_EN
  logic partial_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      data_q    <= '0;
      lanes_q   <= '0;
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      partial_q <= 1'b0;
      err_q     <= 1'b0;
      if (valid_in) begin
        if (count_q == LAST) begin
          data_q  <= acc_d;
          lanes_q <= LW'(LANES);
          valid_q <= 1'b1;
          count_q <= '0;
          acc_q   <= '0;
          state_q <= IDLE;
        end else begin
          acc_q   <= acc_d;
          count_q <= count_q + 1'b1;
          state_q <= FILL;
        end
      end else if (state_q == FILL) begin
        // Unfilled lanes are already zero because the accumulator clears at every word start.
        data_q    <= acc_q;
        lanes_q   <= LW'(count_q);
        valid_q   <= 1'b1;
        partial_q <= 1'b1;
        count_q   <= '0;
        acc_q     <= '0;
        state_q   <= IDLE;
      end
    end
  end

  assign partial_out = partial_q;
`else
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      count_q <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      lanes_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (valid_in) begin
        if (count_q == LAST) begin
          data_q  <= acc_d;
          lanes_q <= LW'(LANES);
          valid_q <= 1'b1;
          count_q <= '0;
          acc_q   <= '0;
          state_q <= IDLE;
        end else begin
          acc_q   <= acc_d;
          count_q <= count_q + 1'b1;
          state_q <= FILL;
        end
      end else if (state_q == FILL) begin
        // Held beats are dropped; the last emitted word stays on data_out.
        err_q   <= 1'b1;
        count_q <= '0;
        acc_q   <= '0;
        state_q <= IDLE;
      end
    end
  end

  assign partial_out = 1'b0;
`endif

  assign data_out  = data_q;
  assign lanes_out = lanes_q;
  assign valid_out = valid_q;
  assign err_drop  = err_q;

endmodule

// File: tb/tb_width_packer.sv
// Randomized and directed bench for width_packer: three configurations checked against a beat-queue model.
module tb_width_packer;

  logic        clk;
  logic        reset_L;
  logic [7:0]  dAB;
  logic        vAB;
  logic [3:0]  dC;
  logic        vC;

  logic [31:0] dataA, dataB;
  logic [11:0] dataC;
  logic [2:0]  lanesA, lanesB;
  logic [1:0]  lanesC;
  logic        validA, validB, validC;
  logic        partialA, partialB, partialC;
  logic        errA, errB, errC;

  int passCnt = 0;
  int totalCnt = 0;

  // Model state: beats held per instance, and expected output values.
  int          inW[3]   = '{8, 8, 4};
  int          nLanes[3] = '{4, 4, 3};
  int          msbF[3]  = '{1, 0, 1};
  logic [7:0]  heldBeats[3][4];
  int          heldCnt[3];
  logic [31:0] expData[3];
  logic [2:0]  expLanes[3];
  logic        expValid[3], expPartial[3], expErr[3];

  logic [31:0] obsData[3];
  logic [2:0]  obsLanes[3];
  logic        obsValid[3], obsPartial[3], obsErr[3];

  width_packer #(.IN_W(8), .LANES(4), .MSB_FIRST(1)) uA (
    .clk(clk), .reset_L(reset_L), .data_in(dAB), .valid_in(vAB),
    .data_out(dataA), .valid_out(validA), .lanes_out(lanesA),
    .partial_out(partialA), .err_drop(errA));

  width_packer #(.IN_W(8), .LANES(4), .MSB_FIRST(0)) uB (
    .clk(clk), .reset_L(reset_L), .data_in(dAB), .valid_in(vAB),
    .data_out(dataB), .valid_out(validB), .lanes_out(lanesB),
    .partial_out(partialB), .err_drop(errB));

  width_packer #(.IN_W(4), .LANES(3), .MSB_FIRST(1)) uC (
    .clk(clk), .reset_L(reset_L), .data_in(dC), .valid_in(vC),
    .data_out(dataC), .valid_out(validC), .lanes_out(lanesC),
    .partial_out(partialC), .err_drop(errC));

  assign obsData[0] = dataA;
  assign obsData[1] = dataB;
  assign obsData[2] = {20'h0, dataC};
  assign obsLanes[0] = lanesA;
  assign obsLanes[1] = lanesB;
  assign obsLanes[2] = {1'b0, lanesC};
  assign obsValid[0] = validA;
  assign obsValid[1] = validB;
  assign obsValid[2] = validC;
  assign obsPartial[0] = partialA;
  assign obsPartial[1] = partialB;
  assign obsPartial[2] = partialC;
  assign obsErr[0] = errA;
  assign obsErr[1] = errB;
  assign obsErr[2] = errC;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word built from the held beats: first beat at the top (MSB-first) or bottom, rest zero.
  function automatic logic [31:0] packWord(int k);
    logic [31:0] w;
    int outW;
    w = 32'h0;
    outW = inW[k] * nLanes[k];
    for (int i = 0; i < heldCnt[k]; i++) begin
      if (msbF[k] != 0) w = w | (32'(heldBeats[k][i]) << (outW - inW[k] * (i + 1)));
      else              w = w | (32'(heldBeats[k][i]) << (inW[k] * i));
    end
    return w;
  endfunction

  task automatic modelClear();
    for (int k = 0; k < 3; k++) begin
      heldCnt[k] = 0;
      expData[k] = '0;
      expLanes[k] = '0;
      expValid[k] = 1'b0;
      expPartial[k] = 1'b0;
      expErr[k] = 1'b0;
    end
  endtask

  task automatic modelEdge(int k, logic v, logic [7:0] d);
    expValid[k] = 1'b0;
    expPartial[k] = 1'b0;
    expErr[k] = 1'b0;
    if (v) begin
      heldBeats[k][heldCnt[k]] = (k == 2) ? (d & 8'h0F) : d;
      heldCnt[k]++;
      if (heldCnt[k] == nLanes[k]) begin
        expData[k] = packWord(k);
        expLanes[k] = 3'(nLanes[k]);
        expValid[k] = 1'b1;
        heldCnt[k] = 0;
      end
    end else if (heldCnt[k] > 0) begin
`ifdef WIDTH_PACKER_PARTIAL_FLUSH_EN
      expData[k] = packWord(k);
      expLanes[k] = 3'(heldCnt[k]);
      expValid[k] = 1'b1;
      expPartial[k] = 1'b1;
`else
      expErr[k] = 1'b1;
`endif
      heldCnt[k] = 0;
    end
  endtask

  // Drive one cycle of stimulus, advance the model across the edge, settle past it.
  task automatic applyStimulus(logic va, logic [7:0] da, logic vc, logic [3:0] dc);
    vAB = va;
    dAB = da;
    vC = vc;
    dC = dc;
    @(posedge clk);
    modelEdge(0, va, da);
    modelEdge(1, va, da);
    modelEdge(2, vc, {4'h0, dc});
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    vAB = 1'b0; dAB = '0; vC = 1'b0; dC = '0;
    modelClear();
    #12;
    for (int k = 0; k < 3; k++) begin
      totalCnt++;
      if ({obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k]} !== 38'h0)
        $display("[TB] FAIL reset inst%0d: got data=%h lanes=%0d v=%b p=%b e=%b, expected all zero",
                 k, obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k]);
      else passCnt++;
    end
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_full_word();
    logic [7:0] beatsAB[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [3:0] beatsC[4] = '{4'hA, 4'hB, 4'hC, 4'h0};
    for (int s = 0; s < 5; s++) begin
      if (s < 4) applyStimulus(1'b1, beatsAB[s], s < 3, beatsC[s]);
      else       applyStimulus(1'b0, 8'h00, 1'b0, 4'h0);
      for (int k = 0; k < 3; k++) begin
        totalCnt++;
        if ({obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k]} !==
            {expData[k], expLanes[k], expValid[k], expPartial[k], expErr[k]})
          $display("[TB] FAIL full_word inst%0d step%0d: got data=%h lanes=%0d v=%b p=%b e=%b, expected data=%h lanes=%0d v=%b p=%b e=%b",
                   k, s, obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k],
                   expData[k], expLanes[k], expValid[k], expPartial[k], expErr[k]);
        else passCnt++;
      end
      if (s == 2) begin
        totalCnt++;
        if ({dataC, lanesC, validC} !== {12'hABC, 2'd3, 1'b1})
          $display("[TB] FAIL word_4x3: got data=%h lanes=%0d v=%b, expected data=abc lanes=3 v=1", dataC, lanesC, validC);
        else passCnt++;
      end
      if (s == 3) begin
        totalCnt++;
        if ({dataA, lanesA, validA} !== {32'hAABBCCDD, 3'd4, 1'b1})
          $display("[TB] FAIL word_msb: got data=%h lanes=%0d v=%b, expected data=aabbccdd lanes=4 v=1", dataA, lanesA, validA);
        else passCnt++;
        totalCnt++;
        if ({dataB, validB} !== {32'hDDCCBBAA, 1'b1})
          $display("[TB] FAIL word_lsb: got data=%h v=%b, expected data=ddccbbaa v=1", dataB, validB);
        else passCnt++;
      end
      if (s == 4) begin
        totalCnt++;
        if ({dataA, validA} !== {32'hAABBCCDD, 1'b0})
          $display("[TB] FAIL hold_after_pulse: got data=%h v=%b, expected data=aabbccdd v=0", dataA, validA);
        else passCnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    for (int s = 0; s < 9; s++) begin
      if (s < 8) applyStimulus(1'b1, 8'(s + 1), 1'b1, 4'($urandom_range(15)));
      else       applyStimulus(1'b0, 8'h00, 1'b0, 4'h0);
      for (int k = 0; k < 3; k++) begin
        totalCnt++;
        if ({obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k]} !==
            {expData[k], expLanes[k], expValid[k], expPartial[k], expErr[k]})
          $display("[TB] FAIL back_to_back inst%0d step%0d: got data=%h lanes=%0d v=%b p=%b e=%b, expected data=%h lanes=%0d v=%b p=%b e=%b",
                   k, s, obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k],
                   expData[k], expLanes[k], expValid[k], expPartial[k], expErr[k]);
        else passCnt++;
      end
      if (validA) pulses++;
      if (s == 3 || s == 7) begin
        totalCnt++;
        if ({dataA, validA} !== {((s == 3) ? 32'h01020304 : 32'h05060708), 1'b1})
          $display("[TB] FAIL b2b_pulse step%0d: got data=%h v=%b, expected data=%h v=1",
                   s, dataA, validA, (s == 3) ? 32'h01020304 : 32'h05060708);
        else passCnt++;
      end
    end
    totalCnt++;
    if (pulses !== 2)
      $display("[TB] FAIL b2b_pulse_count: got %0d, expected 2", pulses);
    else passCnt++;
  endtask

  task automatic test_abort();
    applyStimulus(1'b1, 8'h11, 1'b1, 4'h1);
    applyStimulus(1'b1, 8'h22, 1'b1, 4'h2);
    applyStimulus(1'b0, 8'h00, 1'b0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      totalCnt++;
      if ({obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k]} !==
          {expData[k], expLanes[k], expValid[k], expPartial[k], expErr[k]})
        $display("[TB] FAIL abort inst%0d: got data=%h lanes=%0d v=%b p=%b e=%b, expected data=%h lanes=%0d v=%b p=%b e=%b",
                 k, obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k],
                 expData[k], expLanes[k], expValid[k], expPartial[k], expErr[k]);
      else passCnt++;
    end
    totalCnt++;
`ifdef WIDTH_PACKER_PARTIAL_FLUSH_EN
    if ({dataA, lanesA, validA, partialA, errA} !== {32'h11220000, 3'd2, 1'b1, 1'b1, 1'b0})
      $display("[TB] FAIL abort_flush: got data=%h lanes=%0d v=%b p=%b e=%b, expected data=11220000 lanes=2 v=1 p=1 e=0",
               dataA, lanesA, validA, partialA, errA);
    else passCnt++;
`else
    if ({dataA, lanesA, validA, partialA, errA} !== {32'h05060708, 3'd4, 1'b0, 1'b0, 1'b1})
      $display("[TB] FAIL abort_drop: got data=%h lanes=%0d v=%b p=%b e=%b, expected data=05060708 lanes=4 v=0 p=0 e=1",
               dataA, lanesA, validA, partialA, errA);
    else passCnt++;
`endif
    applyStimulus(1'b0, 8'h00, 1'b0, 4'h0);
    totalCnt++;
    if ({validA, partialA, errA} !== 3'b000)
      $display("[TB] FAIL abort_pulse_width: got v=%b p=%b e=%b, expected 000", validA, partialA, errA);
    else passCnt++;
  endtask

  task automatic test_reset_midword();
    logic [7:0] beats[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    applyStimulus(1'b1, 8'h11, 1'b1, 4'h1);
    applyStimulus(1'b1, 8'h22, 1'b1, 4'h2);
    vAB = 1'b0; vC = 1'b0;
    reset_L = 1'b0;
    modelClear();
    #1;
    for (int k = 0; k < 3; k++) begin
      totalCnt++;
      if ({obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k]} !== 38'h0)
        $display("[TB] FAIL midword_reset inst%0d: got data=%h lanes=%0d v=%b p=%b e=%b, expected all zero",
                 k, obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k]);
      else passCnt++;
    end
    @(posedge clk);
    #1;
    totalCnt++;
    if ({validA, errA, validC, errC} !== 4'b0000)
      $display("[TB] FAIL midword_no_pulse: got vA=%b eA=%b vC=%b eC=%b, expected 0000", validA, errA, validC, errC);
    else passCnt++;
    @(negedge clk);
    reset_L = 1'b1;
    for (int s = 0; s < 4; s++) applyStimulus(1'b1, beats[s], 1'b0, 4'h0);
    totalCnt++;
    if ({dataA, lanesA, validA} !== {32'hAABBCCDD, 3'd4, 1'b1})
      $display("[TB] FAIL after_reset_word: got data=%h lanes=%0d v=%b, expected data=aabbccdd lanes=4 v=1", dataA, lanesA, validA);
    else passCnt++;
  endtask

  task automatic test_random();
    for (int s = 0; s < 400; s++) begin
      applyStimulus($urandom_range(3) != 0, 8'($urandom_range(255)),
                    $urandom_range(4) != 0, 4'($urandom_range(15)));
      for (int k = 0; k < 3; k++) begin
        totalCnt++;
        if ({obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k]} !==
            {expData[k], expLanes[k], expValid[k], expPartial[k], expErr[k]})
          $display("[TB] FAIL random inst%0d cyc%0d: got data=%h lanes=%0d v=%b p=%b e=%b, expected data=%h lanes=%0d v=%b p=%b e=%b",
                   k, s, obsData[k], obsLanes[k], obsValid[k], obsPartial[k], obsErr[k],
                   expData[k], expLanes[k], expValid[k], expPartial[k], expErr[k]);
        else passCnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_back_to_back();
    test_abort();
    test_reset_midword();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/width_packer.md
WIDTH_PACKER -- requirements
Module: width_packer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): IN_W, 8, input beat width in bits (>=1).
REQ-002 LANES, 4, beats packed per output word (>=2); OUT_W = IN_W*LANES is derived, not settable.
REQ-003 MSB_FIRST, 1, 1 = first beat lands in data_out[OUT_W-1 -: IN_W]; 0 = first beat lands in data_out[IN_W-1:0].
REQ-004 Ports SHALL be (name direction width meaning): clk  input  1  single clock, all state on rising edge.
REQ-005 reset_L  input  1  reset, asynchronous assert, active-low.
REQ-006 data_in  input  IN_W  input beat.
REQ-007 valid_in  input  1  beat qualifier; beat accepted on any rising edge where valid_in=1.
REQ-008 data_out  output  OUT_W  packed word, registered, held between words.
REQ-009 valid_out  output  1  one-cycle pulse marking a new data_out.
REQ-010 lanes_out  output  $clog2(LANES+1)  number of received lanes in the current data_out.
REQ-011 partial_out  output  1  qualifies valid_out: 1 = word is a zero-padded partial.
REQ-012 err_drop  output  1  one-cycle pulse: partial word discarded.

Function
REQ-013 Block SHALL keep a lane counter 0..LANES-1 and an OUT_W accumulation register; counter states: IDLE (0, nothing held) and FILL (1..LANES-1 beats held).
REQ-014 Each accepted beat SHALL be written into the lane given by the counter (lane order per MSB_FIRST) and increment the counter.
REQ-015 Beat accepted at counter=LANES-1 SHALL load data_out with the complete word on that same edge, set valid_out=1, lanes_out=LANES, partial_out=0, and return the counter to 0 (wrap).
REQ-016 Latency: valid_out SHALL be high exactly in the cycle after the edge capturing the last beat; continuous valid_in SHALL yield one pulse every LANES cycles with no lost beats.
REQ-017 valid_out, partial_out, err_drop SHALL each be high for at most one cycle per event; data_out and lanes_out SHALL hold until the next emitted word.
REQ-018 valid_in=0 with counter=0 SHALL be idle: no output change besides pulses returning to 0.
REQ-019 valid_in=0 with counter>0 SHALL be an abort: counter returns to 0 and accumulation register clears on that edge; abort handling per REQ-026/REQ-027.
REQ-020 A new beat on the edge after an abort SHALL start a fresh word at lane 0.
REQ-021 No backpressure: block SHALL accept a beat every cycle valid_in=1.

Reset
REQ-022 reset_L=0 SHALL asynchronously clear counter, accumulation register, data_out, lanes_out, valid_out, partial_out, err_drop to 0.
REQ-023 Reset mid-word SHALL discard held beats with no valid_out or err_drop pulse.
REQ-024 First beat after reset_L deasserts SHALL be lane 0.

Configuration
REQ-025 Macro WIDTH_PACKER_PARTIAL_FLUSH_EN SHALL select abort handling.
REQ-026 Defined: abort SHALL load data_out with held beats in their lane positions, unfilled lanes 0, valid_out=1, partial_out=1, lanes_out=held count, err_drop=0.
REQ-027 Undefined: abort SHALL leave data_out/lanes_out unchanged, valid_out=0, pulse err_drop=1; partial_out SHALL be tied 0.

Verification (IN_W=8, LANES=4 unless stated)
REQ-028 MSB_FIRST=1, beats AA,BB,CC,DD consecutive -> data_out=AABBCCDD, lanes_out=4, valid_out=1 for exactly one cycle, in cycle after beat DD.
REQ-029 MSB_FIRST=0, same beats -> data_out=DDCCBBAA.
REQ-030 8 consecutive beats 01..08 -> pulses 01020304 then 05060708, exactly 4 cycles apart.
REQ-031 Beats 11,22 then valid_in=0 -> with macro: data_out=11220000, partial_out=1, lanes_out=2; without: err_drop one-cycle pulse, data_out unchanged, valid_out stays 0.
REQ-032 Beats 11,22, reset_L pulsed low, then AA,BB,CC,DD -> all outputs 0 during reset, no pulse, then data_out=AABBCCDD.
REQ-033 IN_W=4, LANES=3, MSB_FIRST=1, beats A,B,C -> data_out=12'hABC, lanes_out=3.
